// File: rtl/card_pkg.sv
// card_pkg: shared constants, types and FSM states for the card blitter.
package card_pkg;
    localparam int CARD_W = 16;
    localparam int CARD_H = 32;
    localparam int SCREEN_W = 256;
    localparam int SCREEN_H = 240;
    localparam logic [2:0] TRANSPARENT = 3'b000;
    typedef logic [2:0] pixel_t;
    typedef logic [8:0] card_addr_t;
    typedef logic [15:0] fb_addr_t;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} blit_state_t;
endpackage

// File: rtl/blit_coord_pipe.sv
// blit_coord_pipe: aligns card coordinates with read data, clips and registers the frame-buffer write.
module blit_coord_pipe
    import card_pkg::*;
#(
    parameter int CW = 4,
    parameter int SW = 256,
    parameter int SH = 240,
    parameter pixel_t TR = 3'b000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       re,
    input  card_addr_t addr,
    input  logic [7:0] x0,
    input  logic [7:0] y0,
    input  pixel_t     pix,
    output logic       fb_we,
    output fb_addr_t   fb_addr,
    output pixel_t     fb_data
);
    logic          v;
    logic [CW-1:0] col;
    logic [8-CW:0] row;
    logic [8:0]    sx, sy;
    // 9-bit sums so an overflow past the edge is clipped rather than wrapped
    assign sx = {1'b0, x0} + 9'(col);
    assign sy = {1'b0, y0} + 9'(row);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v <= 1'b0;
            col <= '0;
            row <= '0;
            fb_we <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            v <= re;
            col <= addr[CW-1:0];
            row <= addr[8:CW];
            fb_we <= v && ({1'b0, sx} < 10'(SW)) && ({1'b0, sy} < 10'(SH)) && pix != TR;
            fb_addr <= {sy[7:0], sx[7:0]};
            fb_data <= pix;
        end
    end
endmodule

// File: rtl/card_blitter.sv
// card_blitter: copies a card bitmap into the frame buffer with clipping and transparency.
module card_blitter
    import card_pkg::*;
#(
    parameter int CARD_W = card_pkg::CARD_W,
    parameter int CARD_H = card_pkg::CARD_H,
    parameter int SCREEN_W = card_pkg::SCREEN_W,
    parameter int SCREEN_H = card_pkg::SCREEN_H,
    parameter pixel_t TRANSPARENT = card_pkg::TRANSPARENT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  xPos,
    input  logic [7:0]  yPos,
    output logic        cardRE,
    output logic [8:0]  cardAddr,
    input  logic [2:0]  cardData,
    output logic        fbWE,
    output logic [15:0] fbAddr,
    output logic [2:0]  fbData,
    output logic        busy,
    output logic        done
);
    localparam card_addr_t LAST = card_addr_t'(CARD_W * CARD_H - 1);
    blit_state_t state;
    card_addr_t  k;
    logic [7:0]  x0, y0;
    assign cardRE = state == FETCH;
    assign cardAddr = k;
    assign busy = state == FETCH || state == DRAIN;
    assign done = state == DONE;
    // k doubles as the drain counter and is cleared in DONE so IDLE always shows address 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k <= '0;
            x0 <= '0;
            y0 <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FETCH;
                    k <= '0;
                    x0 <= xPos;
                    y0 <= yPos;
                end
                FETCH: begin
                    k <= k + 1'b1;
                    state <= k == LAST ? DRAIN : FETCH;
                end
                DRAIN: begin
                    k <= k + 1'b1;
                    state <= k[0] ? DONE : DRAIN;
                end
                default: begin
                    k <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
    blit_coord_pipe #(
        .CW($clog2(CARD_W)),
        .SW(SCREEN_W),
        .SH(SCREEN_H),
        .TR(TRANSPARENT)
    ) u_pipe (
        .clock(clock),
        .reset_n(reset_n),
        .re(cardRE),
        .addr(k),
        .x0(x0),
        .y0(y0),
        .pix(cardData),
        .fb_we(fbWE),
        .fb_addr(fbAddr),
        .fb_data(fbData)
    );
endmodule

// File: tb/tb_card_blitter.sv
// tb_card_blitter: scoreboard bench driving blits against a card memory model.
module tb_card_blitter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  xPos = '0, yPos = '0;
    logic        cardRE, fbWE, busy, done;
    logic [8:0]  cardAddr;
    logic [2:0]  cardData = '0;
    logic [15:0] fbAddr;
    logic [2:0]  fbData;
    logic [2:0]  mem [512];
    logic [18:0] q [$];
    int tests = 0, fails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) if (cardRE) cardData <= mem[cardAddr];

    card_blitter dut (
        .clock(clock), .reset_n(reset_n), .start(start), .xPos(xPos), .yPos(yPos),
        .cardRE(cardRE), .cardAddr(cardAddr), .cardData(cardData),
        .fbWE(fbWE), .fbAddr(fbAddr), .fbData(fbData), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 512; i++)
            mem[i] = mode == 0 ? 3'b101 : mode == 1 ? 3'b010 : (i % 2 == 1 ? 3'b111 : 3'b000);
    endtask

    task automatic expect_writes(input int x, input int y);
        q.delete();
        for (int i = 0; i < 512; i++) begin
            int sx, sy;
            sx = x + i % 16;
            sy = y + i / 16;
            if (sx < 256 && sy < 240 && mem[i] != 3'b000)
                q.push_back({sy[7:0], sx[7:0], mem[i]});
        end
    endtask

    task automatic run_blit(input logic [7:0] x, input logic [7:0] y, input int n_exp,
                            input int fc_exp, input int fa_exp, input int lc_exp, input int la_exp,
                            input int sb_at, input int rst_at);
        int wr = 0, dn = 0, dc = -1, bf = -1, bl = -1, fw = -1, lw = -1, fa = 0, la = 0;
        logic [18:0] e;
        @(negedge clock);
        start = 1'b1;
        xPos = x;
        yPos = y;
        expect_writes(x, y);
        for (int c = 1; c <= 515; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c == sb_at) begin start = 1'b1; xPos = 8'd100; end
            if (c == sb_at + 1) begin start = 1'b0; xPos = x; end
            if (c == rst_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_outputs", 32'({cardRE, cardAddr, fbWE, fbAddr, fbData, busy, done}), 0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    if (done) dn++;
                end
                check("rst_no_done", dn, 0);
                q.delete();
                reset_n = 1'b1;
                return;
            end
            if (busy) begin
                if (bf < 0) bf = c;
                bl = c;
            end
            if (done) begin dn++; dc = c; end
            if (fbWE) begin
                wr++;
                if (fw < 0) begin fw = c; fa = 32'(fbAddr); end
                lw = c;
                la = 32'(fbAddr);
                if (q.size() == 0) check("extra_write", 32'(fbAddr), 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    check("write", 32'({fbAddr, fbData}), 32'(e));
                end
            end
        end
        check("write_count", wr, n_exp);
        check("missing_writes", q.size(), 0);
        check("first_cycle", fw, fc_exp);
        check("first_addr", fa, fa_exp);
        check("last_cycle", lw, lc_exp);
        check("last_addr", la, la_exp);
        check("busy_first", bf, 1);
        check("busy_last", bl, 514);
        check("done_count", dn, 1);
        check("done_cycle", dc, 515);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b1;
        fill(0);
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({cardRE, cardAddr, fbWE, fbAddr, fbData, busy, done}), 0);
        start = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_hold", 32'({busy, cardRE, done}), 0);
        end
        run_blit(8'd0, 8'd0, 512, 3, 16'h0000, 514, 16'h1F0F, -10, -1);
        repeat (3) @(negedge clock);
        fill(1);
        run_blit(8'd250, 8'd230, 60, 3, 16'hE6FA, 152, 16'hEFFF, -10, -1);
        repeat (3) @(negedge clock);
        fill(2);
        run_blit(8'd16, 8'd8, 256, 4, 16'h0811, 514, 16'h271F, -10, -1);
        repeat (3) @(negedge clock);
        fill(0);
        run_blit(8'd20, 8'd40, 512, 3, 16'h2814, 514, 16'h4723, 100, -1);
        run_blit(8'd0, 8'd0, 512, 3, 16'h0000, 514, 16'h1F0F, -10, -1);
        repeat (3) @(negedge clock);
        run_blit(8'd0, 8'd0, 512, 3, 16'h0000, 514, 16'h1F0F, -10, 200);
        repeat (2) @(negedge clock);
        run_blit(8'd5, 8'd7, 512, 3, 16'h0705, 514, 16'h2614, -10, -1);
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/card_blitter.md
# card_blitter

Sprite copy engine for the 256x240 VGA path. It reads a 16x32 card bitmap (512 three-bit pixels) out of a card memory such as card8 and writes it into the frame-buffer RAM at a requested screen position. Pixels with the transparent colour are skipped, and pixels falling off-screen are clipped. It sits between the game-control logic, which issues `start`, and the card and frame-buffer memories, which have a one-cycle registered read and a write-enable port.

## Interface

Parameters:
- `CARD_W`, default 16: card width in pixels (power of two).
- `CARD_H`, default 32: card height in pixels; `CARD_W*CARD_H` = 512.
- `SCREEN_W`, default 256: visible width.
- `SCREEN_H`, default 240: visible height.
- `TRANSPARENT`, default 3'b000: colour that is never written.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a blit; sampled only in IDLE.
- `xPos`  in  8  screen column of the card's top-left pixel.
- `yPos`  in  8  screen row of the card's top-left pixel.
- `cardRE`  out  1  read enable to card memory.
- `cardAddr`  out  9  card memory read address; pixel index k = row*16 + col.
- `cardData`  in  3  card memory read data, valid the cycle after `cardAddr`.
- `fbWE`  out  1  frame-buffer write enable.
- `fbAddr`  out  16  frame-buffer address = {y[7:0], x[7:0]}.
- `fbData`  out  3  frame-buffer write data.
- `busy`  out  1  high from the cycle after start is accepted through the last write cycle.
- `done`  out  1  one-cycle pulse after the last write.

## Operation

- State machine: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- **IDLE:** when `start`=1, latch `xPos`/`yPos`, clear the pixel counter k, and go to FETCH. `start` in any other state is ignored; latched positions do not change mid-blit.
- **FETCH:** 512 cycles. Present `cardAddr`=k with `cardRE`=1, then increment k. After k=511, go to DRAIN.
- **DRAIN:** 2 cycles. Flushes the read and write pipeline. `cardRE`=0.
- **DONE:** 1 cycle. `done`=1, `busy`=0. Then go to IDLE.
- Coordinate pipeline: col = k[3:0] and row = k[8:4] are delayed one cycle to align with `cardData`.
  - sx = xPos + col, computed 9 bits wide.
  - sy = yPos + row, computed 9 bits wide.
- Write qualification. The registered `fbWE` is 1 only when all of these hold for the aligned pixel:
  - the aligned pixel is valid;
  - sx < 256 (sx[8]=0);
  - sy < 240;
  - `cardData` != `TRANSPARENT`.
- Clipped or transparent pixels still consume their cycle; the write is simply suppressed.
- `fbAddr` = {sy[7:0], sx[7:0]} and `fbData` = `cardData`, registered.
- No wrap-around: pixels past the right or bottom edge are dropped, never wrapped to column 0 or row 0.
- Reset (async, at any time, including mid-blit): state returns to IDLE, k = 0, and the pipeline valid flags clear. All outputs are 0: `cardRE`, `cardAddr`, `fbWE`, `fbAddr`, `fbData`, `busy`, `done`. No `done` is issued for the aborted blit.

## Timing

- Cycle 0: `start` sampled in IDLE.
- Cycles 1..512: `cardAddr` = 0..511; `busy`=1.
- Pixel k: its address appears in cycle 1+k, its data in cycle 2+k, and its frame-buffer write on the `fb*` ports in cycle 3+k.
- Last possible write is in cycle 514, which is the final DRAIN cycle. `busy`=1 in cycles 1..514.
- Cycle 515: `done`=1, `busy`=0.
- Cycle 516: IDLE; a new `start` is accepted from this cycle on.
- Throughput: one pixel per cycle. Fixed 515-cycle blit, independent of clipping or transparency.
- At most one write per cycle; the `fb*` outputs are registered, with no combinational path from `cardData`.

## Structure

- Package `card_pkg`:
  - constants `CARD_W`, `CARD_H`, `SCREEN_W`, `SCREEN_H`, `TRANSPARENT`;
  - typedefs `pixel_t` (logic [2:0]), `card_addr_t` (logic [8:0]), `fb_addr_t` (logic [15:0]);
  - enum `blit_state_t` {IDLE, FETCH, DRAIN, DONE}.
- Sub-module `blit_coord_pipe`: the valid/col/row delay stage plus the clip comparison. This keeps the FSM and counter in `card_blitter` separate from the address arithmetic.

## Test plan

- **Reset:** assert `reset_n`=0 with `start`=1 -> all outputs 0. After release, the block stays in IDLE until `start`.
- **Full blit:** card filled with 3'b101, xPos=0, yPos=0 -> exactly 512 writes.
  - First write in cycle 3 with `fbAddr`=16'h0000.
  - Last write in cycle 514 with `fbAddr`=16'h1F0F.
  - `done` high in cycle 515 only.
- **Clipping:** card all 3'b010, xPos=250, yPos=230 -> exactly 60 writes (cols 0-5 x rows 0-9).
  - First `fbAddr`=16'hE6FA.
  - No write with x<250 or y<230; `done` still in cycle 515.
- **Transparency:** card alternating 3'b000/3'b111 by k parity, xPos=16, yPos=8 -> 256 writes, all `fbData`=3'b111, all at odd col.
- **Start while busy:** second `start` in cycle 100 with new xPos -> ignored; addresses keep the original origin. A `start` in cycle 516 is accepted, with `busy` rising in cycle 517.
- **Mid-blit reset:** `reset_n` low in cycle 200 -> outputs 0 immediately and no `done`. A subsequent blit completes with exactly 512 writes.
